// File: rtl/playfield_bg.sv
// Playfield background renderer: river/grass/road tile bands, 2-stage pixel pipeline and level-clear flash FSM.
// Optional animated river ripple is built only when PLAYFIELD_WATER_ANIM_EN is defined.
module playfield_bg #(
    parameter logic [9:0] X_LEFT        = 10'd96,
    parameter logic [9:0] X_RIGHT       = 10'd544,
    parameter int         BLOCK_LOG2    = 5,
    parameter int         ROW_COUNT     = 15,
    parameter int         RIVER_FIRST   = 1,
    parameter int         RIVER_LAST    = 6,
    parameter int         FLASH_FRAMES  = 8,
    parameter int         FLASH_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       on,
    input  logic       frame_tick,
    input  logic       flash_req,
    input  logic [9:0] colPos,
    input  logic [9:0] rowPos,
    output logic [5:0] color,
    output logic       flash_busy
);
    localparam logic [5:0] BLUE     = 6'b000011;
    localparam logic [5:0] WATER_HI = 6'b010111;
    localparam logic [5:0] GREEN    = 6'b001101;
    localparam logic [5:0] BLACK    = 6'b000000;
    localparam logic [5:0] WHITE    = 6'b111111;

    localparam int FW = $clog2(FLASH_FRAMES) + 1;
    localparam int TW = $clog2(FLASH_TOGGLES) + 1;
    localparam logic [FW-1:0] FRAME_LAST  = FW'(FLASH_FRAMES - 1);
    localparam logic [TW-1:0] TOGGLE_LAST = TW'(FLASH_TOGGLES - 1);

    localparam logic [9:0] ROW_LIM   = 10'(ROW_COUNT);
    localparam logic [9:0] RIV_FIRST = 10'(RIVER_FIRST);
    localparam logic [9:0] RIV_LAST  = 10'(RIVER_LAST);
    localparam logic [9:0] GRASS_MID = 10'(RIVER_LAST + 1);
    localparam logic [9:0] GRASS_END = 10'(ROW_COUNT - 1);

    typedef enum logic [1:0] {IDLE, FLASH_LIT, FLASH_DARK} state_t;
    typedef enum logic [1:0] {REG_ROAD, REG_RIVER, REG_GRASS} region_t;

    state_t        state, state_n;
    logic [FW-1:0] frame_cnt, frame_n;
    logic [TW-1:0] toggle_cnt, toggle_n;

    logic [9:0] tile_row;
    logic       in_field;
    region_t    region;
    logic       ripple;

    assign tile_row = rowPos >> BLOCK_LOG2;
    assign in_field = (colPos >= X_LEFT) && (colPos < X_RIGHT) && (tile_row < ROW_LIM);

    // River wins over grass so a misconfigured overlap still renders water.
    always_comb begin
        region = REG_ROAD;
        if (tile_row >= RIV_FIRST && tile_row <= RIV_LAST)
            region = REG_RIVER;
        else if (tile_row == 10'd0 || tile_row == GRASS_MID || tile_row == GRASS_END)
            region = REG_GRASS;
    end

`ifdef PLAYFIELD_WATER_ANIM_EN
    logic [1:0] phase;
    logic [1:0] ripple_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           phase <= 2'd0;
        else if (frame_tick) phase <= phase + 2'd1;
    end

    // 2-bit sum wraps, giving the mod-4 of (col/8 + row + phase) for free.
    assign ripple_sum = colPos[4:3] + tile_row[1:0] + phase;
    assign ripple     = (ripple_sum == 2'd0);
`else
    assign ripple = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        frame_n  = frame_cnt;
        toggle_n = toggle_cnt;
        case (state)
            IDLE: begin
                if (flash_req) begin
                    state_n  = FLASH_LIT;
                    frame_n  = '0;
                    toggle_n = '0;
                end
            end
            default: begin
                if (frame_tick) begin
                    if (frame_cnt == FRAME_LAST) begin
                        frame_n  = '0;
                        toggle_n = toggle_cnt + 1'b1;
                        if (toggle_cnt == TOGGLE_LAST) state_n = IDLE;
                        else state_n = (state == FLASH_LIT) ? FLASH_DARK : FLASH_LIT;
                    end else begin
                        frame_n = frame_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            toggle_cnt <= '0;
            flash_busy <= 1'b0;
        end else begin
            state      <= state_n;
            frame_cnt  <= frame_n;
            toggle_cnt <= toggle_n;
            flash_busy <= (state_n != IDLE);
        end
    end

    logic    on_s1, in_field_s1, ripple_s1, lit_s1;
    region_t region_s1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_s1       <= 1'b0;
            in_field_s1 <= 1'b0;
            ripple_s1   <= 1'b0;
            lit_s1      <= 1'b0;
            region_s1   <= REG_ROAD;
        end else begin
            on_s1       <= on;
            in_field_s1 <= in_field;
            ripple_s1   <= ripple;
            lit_s1      <= (state == FLASH_LIT);
            region_s1   <= region;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color <= BLACK;
        end else if (!on_s1 || !in_field_s1) begin
            color <= BLACK;
        end else begin
            case (region_s1)
                REG_RIVER: color <= ripple_s1 ? WATER_HI : BLUE;
                REG_GRASS: color <= lit_s1 ? WHITE : GREEN;
                default:   color <= BLACK;
            endcase
        end
    end
endmodule

// File: tb/tb_playfield_bg.sv
// Bench for playfield_bg: directed boundary/flash/reset steps followed by random pixels,
// all compared against a frame-count level model of the playfield.
module tb_playfield_bg;
    logic       clk = 1'b0;
    logic       reset;
    logic       on;
    logic       frame_tick;
    logic       flash_req;
    logic [9:0] colPos;
    logic [9:0] rowPos;
    logic [5:0] color;
    logic       flash_busy;

    localparam logic [5:0] BLUE     = 6'b000011;
    localparam logic [5:0] WATER_HI = 6'b010111;
    localparam logic [5:0] GREEN    = 6'b001101;
    localparam logic [5:0] BLACK    = 6'b000000;
    localparam logic [5:0] WHITE    = 6'b111111;

    playfield_bg dut (
        .clk        (clk),
        .reset      (reset),
        .on         (on),
        .frame_tick (frame_tick),
        .flash_req  (flash_req),
        .colPos     (colPos),
        .rowPos     (rowPos),
        .color      (color),
        .flash_busy (flash_busy)
    );

    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;

    // Reference state: busy flag, frame ticks since the flash started, ripple phase.
    bit m_busy  = 0;
    int m_ticks = 0;
    int m_phase = 0;
    logic [5:0] exp_q[$];

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
        total_checks++;
        assert (obs === expv) passed_checks++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    endtask

    function automatic logic [5:0] model_color(input logic p_on, input int col, input int row_pix);
        int  row;
        bit  lit;
        row = row_pix / 32;
        lit = m_busy && ((m_ticks / 8) % 2 == 0);
        if (!p_on) return BLACK;
        if (col < 96 || col >= 544 || row >= 15) return BLACK;
        if (row >= 1 && row <= 6) begin
`ifdef PLAYFIELD_WATER_ANIM_EN
            if (((col / 8) + row + m_phase) % 4 == 0) return WATER_HI;
`endif
            return BLUE;
        end
        if (row == 0 || row == 7 || row == 14) return lit ? WHITE : GREEN;
        return BLACK;
    endfunction

    task automatic step(input logic s_on, input int s_col, input int s_row,
                        input logic s_tick, input logic s_req);
        on         = s_on;
        colPos     = 10'(s_col);
        rowPos     = 10'(s_row);
        frame_tick = s_tick;
        flash_req  = s_req;
        exp_q.push_back(model_color(s_on, s_col, s_row));
        if (!m_busy && s_req) begin
            m_busy  = 1;
            m_ticks = 0;
        end else if (m_busy && s_tick) begin
            m_ticks++;
            if (m_ticks == 48) m_busy = 0;
        end
        if (s_tick) m_phase = (m_phase + 1) % 4;
        @(posedge clk);
        #1;
        check("color", color, exp_q.pop_front());
        check("flash_busy", 6'(flash_busy), 6'(m_busy));
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_ticks = 0;
        m_phase = 0;
        exp_q.delete();
        exp_q.push_back(BLACK);
    endtask

    initial begin
        reset = 1'b1; on = 1'b0; frame_tick = 1'b0; flash_req = 1'b0;
        colPos = '0; rowPos = '0;
        model_reset();
        #3;
        check("reset_color", color, BLACK);
        check("reset_busy", 6'(flash_busy), 6'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Column boundaries on row 0, then row bands at col 200, then blanking.
        step(1, 95, 0, 0, 0);
        step(1, 96, 0, 0, 0);
        step(1, 543, 0, 0, 0);
        step(1, 544, 0, 0, 0);
        step(1, 200, 32, 0, 0);
        step(1, 200, 224, 0, 0);
        step(1, 200, 480, 0, 0);
        step(1, 200, 479, 0, 0);
        step(0, 200, 0, 0, 0);
        step(1, 200, 0, 0, 0);
        step(1, 200, 0, 0, 0);
        step(1, 200, 0, 0, 0);

        // Full flash: tick every other cycle, second request mid-sequence.
        step(1, 200, 0, 0, 1);
        for (int i = 0; i < 120; i++) begin
            case (i % 3)
                0:       step(1, 200, 0, (i % 2) == 0, i == 21);
                1:       step(1, 300, 40, (i % 2) == 0, i == 21);
                default: step(1, 543, 470, (i % 2) == 0, i == 21);
            endcase
        end

        // Reset while lit must clear outputs immediately.
        step(1, 200, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 200, 0, i % 2, 0);
        reset = 1'b1;
        #1;
        check("midflash_color", color, BLACK);
        check("midflash_busy", 6'(flash_busy), 6'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step(1, 200, 0, 0, 0);

        // Ripple walk along row 1 over a few frames.
        for (int t = 0; t < 5; t++)
            for (int c = 96; c < 136; c += 8) step(1, c, 32, c == 128, 0);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 700), $urandom_range(0, 520),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end
endmodule

// File: doc/playfield_bg.md
PLAYFIELD_BG -- requirements
Module: playfield_bg

Interface
REQ-001 Parameter X_LEFT, default 10'd96: first in-field pixel column (inclusive).
REQ-002 Parameter X_RIGHT, default 10'd544: in-field column limit (exclusive).
REQ-003 Parameter BLOCK_LOG2, default 5: log2 of tile size in pixels (32).
REQ-004 Parameter ROW_COUNT, default 15: number of tile rows in the playfield.
REQ-005 Parameter RIVER_FIRST, default 1, and RIVER_LAST, default 6: inclusive river tile rows.
REQ-006 Parameter FLASH_FRAMES, default 8, and FLASH_TOGGLES, default 6: flash half-period in frames, and number of half-periods.
REQ-007 Port clk, input, 1: single system clock, all state rising-edge.
REQ-008 Port reset, input, 1: asynchronous, active-high reset.
REQ-009 Port on, input, 1: display-active qualifier for the current pixel.
REQ-010 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-011 Port flash_req, input, 1: one-cycle pulse requesting the level-clear flash.
REQ-012 Port colPos, input, 10: current pixel column; rowPos, input, 10: current pixel row.
REQ-013 Port color, output, 6: registered RRGGBB pixel colour; flash_busy, output, 1: flash sequence active.

Function
REQ-014 Tile row = rowPos >> BLOCK_LOG2; in-field = (X_LEFT <= colPos < X_RIGHT) and (tile row < ROW_COUNT); half-open ranges mean no pixel belongs to two regions.
REQ-015 Region priority: river (RIVER_FIRST..RIVER_LAST), else grass (row 0, RIVER_LAST+1, ROW_COUNT-1), else road.
REQ-016 Colours: river BLUE 6'b000011, ripple WATER_HI 6'b010111, grass GREEN 6'b001101, road/out-of-field/blank BLACK 6'b000000, flash WHITE 6'b111111.
REQ-017 Two-stage pipeline: stage 1 registers on, in-field, region and ripple bit; stage 2 registers color; pixel inputs at cycle N appear on color at cycle N+2.
REQ-018 on=0 at cycle N forces color=BLACK at N+2, regardless of region or flash.
REQ-019 Flash FSM states IDLE, FLASH_LIT, FLASH_DARK; flash_req in IDLE -> FLASH_LIT next cycle, frame counter and toggle counter cleared.
REQ-020 In FLASH_LIT/DARK, frame counter counts frame_tick; at FLASH_FRAMES ticks state toggles LIT<->DARK, frame counter clears, toggle counter increments.
REQ-021 When the toggle counter reaches FLASH_TOGGLES, the FSM returns to IDLE on that same tick.
REQ-022 flash_req while not IDLE is ignored; flash_req and frame_tick in the same IDLE cycle: the request is accepted, the tick is not counted.
REQ-023 flash_busy = (state != IDLE), registered with the state.
REQ-024 In FLASH_LIT, in-field grass pixels render WHITE; river and road are unchanged; the state is sampled at stage 1.
REQ-025 Counter widths are sized with $clog2 of their parameter plus one; no counter may wrap before its terminal value.

Reset
REQ-026 reset asserted asynchronously: color=0, flash_busy=0, FSM=IDLE, all counters, ripple phase and pipeline registers 0.
REQ-027 reset mid-flash aborts the sequence; the first valid color is 2 cycles after deassertion.

Configuration
REQ-028 Macro PLAYFIELD_WATER_ANIM_EN defined: a 2-bit phase increments on every frame_tick (wraps 3->0); a river pixel is WATER_HI when ((colPos>>3) + row + phase) mod 4 == 0, else BLUE.
REQ-029 Macro undefined: no phase register is built and all river pixels are BLUE.

Verification
REQ-030 Reset, then sweep row 0, col 95/96/543/544 with on=1 -> color BLACK/GREEN/GREEN/BLACK, each 2 cycles after input.
REQ-031 rowPos 32 (row 1) vs 224 (row 7) vs 480 (row 15), col 200 -> BLUE-or-WATER_HI / GREEN / BLACK.
REQ-032 on=0 at row 0, col 200 -> BLACK; on=1 next cycle -> GREEN two cycles later.
REQ-033 flash_req, then 48 frame_ticks with defaults -> grass WHITE for ticks 0-7, 16-23, 32-39; flash_busy falls on tick 48; second flash_req at tick 10 ignored.
REQ-034 Assert reset during FLASH_LIT -> flash_busy=0 and color=0 immediately; grass returns GREEN after release.
REQ-035 With PLAYFIELD_WATER_ANIM_EN: row 1, col 96, 4 frame_ticks -> WATER_HI pattern shifts one 8-pixel column per tick and repeats after 4 ticks.
